// File: rtl/vehicle_pkg.sv
// Shared vehicle constants: gear codes, refusal reasons and selector states.
package vehicle_pkg;

  localparam int unsigned GEAR_W  = 4;
  localparam int unsigned DENY_W  = 2;
  localparam int unsigned TIMER_W = 24;

  // Gear codes shared with the dynamics block
  localparam logic [GEAR_W-1:0] P_CODE = GEAR_W'(3);
  localparam logic [GEAR_W-1:0] R_CODE = GEAR_W'(6);
  localparam logic [GEAR_W-1:0] N_CODE = GEAR_W'(9);
  localparam logic [GEAR_W-1:0] D_CODE = GEAR_W'(12);

  typedef enum logic [DENY_W-1:0] {
    DENY_NONE     = 2'd0,
    DENY_NO_BRAKE = 2'd1,
    DENY_MOVING   = 2'd2,
    DENY_BAD_KEY  = 2'd3
  } deny_e;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_e;

endpackage

// File: rtl/gear_selector_if.sv
// Keypad request / gear status bundle between the keypad side and the selector.
interface gear_selector_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic       is_brake_normal;
  logic       is_brake_hard;
  logic [7:0] speed;
  logic [3:0] current_gear;
  logic       shifting;
  logic       gear_changed;
  logic       shift_denied;
  logic [1:0] deny_code;

  // Driver side: keypad, pedals and speed source
  modport master (
    output key_valid, key_code, is_brake_normal, is_brake_hard, speed,
    input  current_gear, shifting, gear_changed, shift_denied, deny_code
  );

  // Selector side
  modport slave (
    input  key_valid, key_code, is_brake_normal, is_brake_hard, speed,
    output current_gear, shifting, gear_changed, shift_denied, deny_code
  );

endinterface

// File: rtl/gear_selector.sv
// Gear selector: turns keypad requests into a registered gear code, applying
// brake/standstill interlocks and a fixed-length shift window.
module gear_selector
  import vehicle_pkg::*;
#(
  parameter int unsigned       SHIFT_CYCLES = 5000000,
  parameter logic [GEAR_W-1:0] GEAR_P       = P_CODE,
  parameter logic [GEAR_W-1:0] GEAR_R       = R_CODE,
  parameter logic [GEAR_W-1:0] GEAR_N       = N_CODE,
  parameter logic [GEAR_W-1:0] GEAR_D       = D_CODE
) (
  input  logic           clk,
  input  logic           rst,
  gear_selector_if.slave bus
);

  state_e             state;
  logic [TIMER_W-1:0] timer;
  logic [GEAR_W-1:0]  target;
  logic               key_prev;

  logic key_edge_c;
  logic valid_key_c;
  logic same_gear_c;
  logic brake_missing_c;
  logic moving_block_c;

  // Request decode: one request per key press, plus the interlock conditions
  always_comb begin
    key_edge_c      = bus.key_valid & ~key_prev;
    valid_key_c     = (bus.key_code == GEAR_P) || (bus.key_code == GEAR_R) ||
                      (bus.key_code == GEAR_N) || (bus.key_code == GEAR_D);
    same_gear_c     = (bus.key_code == bus.current_gear);
    brake_missing_c = (bus.current_gear == GEAR_P) &&
                      !bus.is_brake_normal && !bus.is_brake_hard;
    moving_block_c  = ((bus.key_code == GEAR_P) || (bus.key_code == GEAR_R) ||
                       ((bus.current_gear == GEAR_R) && (bus.key_code == GEAR_D))) &&
                      (bus.speed != 8'd0);
  end

  // Selector FSM with registered gear, shift flag and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= '0;
      target           <= GEAR_P;
      key_prev         <= 1'b0;
      bus.current_gear <= GEAR_P;
      bus.shifting     <= 1'b0;
      bus.gear_changed <= 1'b0;
      bus.shift_denied <= 1'b0;
      bus.deny_code    <= DENY_NONE;
    end else begin
      key_prev         <= bus.key_valid;
      bus.gear_changed <= 1'b0;
      bus.shift_denied <= 1'b0;
      case (state)
        IDLE: begin
          if (key_edge_c) begin
            if (!valid_key_c) begin
              bus.shift_denied <= 1'b1;
              bus.deny_code    <= DENY_BAD_KEY;
            end else if (same_gear_c) begin
              // Re-selecting the current gear is a no-op
            end else if (brake_missing_c) begin
              bus.shift_denied <= 1'b1;
              bus.deny_code    <= DENY_NO_BRAKE;
            end else if (moving_block_c) begin
              bus.shift_denied <= 1'b1;
              bus.deny_code    <= DENY_MOVING;
            end else begin
              target       <= bus.key_code;
              timer        <= TIMER_W'(SHIFT_CYCLES - 1);
              bus.shifting <= 1'b1;
              state        <= SHIFTING;
            end
          end
        end
        SHIFTING: begin
          // Old gear stays on the bus until the window expires; new presses are dropped
          if (timer == '0) begin
            bus.current_gear <= target;
            bus.gear_changed <= 1'b1;
            bus.shifting     <= 1'b0;
            state            <= IDLE;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
